// File: rtl/mips_debug_unit_pkg.sv
// Shared command/response codes, controller state encoding and dump geometry
// for the byte-stream MIPS debug controller.
package mips_debug_unit_pkg;

    localparam logic [7:0] CMD_LOAD    = 8'h4C;
    localparam logic [7:0] CMD_RUN     = 8'h52;
    localparam logic [7:0] CMD_STEP    = 8'h53;
    localparam logic [7:0] CMD_DUMP    = 8'h44;
    localparam logic [7:0] CMD_RESET   = 8'h58;

    localparam logic [7:0] RSP_OK      = 8'h4B;
    localparam logic [7:0] RSP_HALT    = 8'h48;
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;

    // PC followed by the 32 general registers
    localparam int DUMP_WORDS = 33;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_BYTE,
        ST_LOAD_WR,
        ST_RUN,
        ST_STEP,
        ST_RESP,
        ST_DUMP_RD,
        ST_DUMP_TX
    } dbg_state_e;

    function automatic logic accepts_rx(dbg_state_e s);
        return (s == ST_IDLE) || (s == ST_LOAD_CNT) || (s == ST_LOAD_BYTE);
    endfunction

endpackage

// File: rtl/mips_debug_unit_tx_shifter.sv
// Serialises a 32-bit word MSB first (or a single byte held in the top byte)
// over a valid/ready byte link; done_o marks acceptance of the final byte.
module mips_debug_unit_tx_shifter (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        one_byte_i,
    input  logic [31:0] word_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        done_o
);

    logic [31:0] shift_q, shift_d;
    logic [2:0]  left_q, left_d;
    logic        valid_q, valid_d;

    always_comb begin
        shift_d = shift_q;
        left_d  = left_q;
        valid_d = valid_q;
        done_o  = valid_q && tx_ready_i && (left_q == 3'd1);
        // Data only moves on a completed handshake, so it is frozen under backpressure
        if (valid_q && tx_ready_i) begin
            shift_d = {shift_q[23:0], 8'h00};
            left_d  = left_q - 3'd1;
            if (left_q == 3'd1) begin
                valid_d = 1'b0;
            end
        end else if (load_i && !valid_q) begin
            shift_d = word_i;
            left_d  = one_byte_i ? 3'd1 : 3'd4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= 32'h0;
            left_q  <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            left_q  <= left_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data_o  = shift_q[31:24];
    assign tx_valid_o = valid_q;

endmodule

// File: rtl/mips_debug_unit.sv
// Host-link debug controller: loads instruction memory, runs/steps/resets the
// MIPS core and streams back PC plus register file after every stop.
module mips_debug_unit
    import mips_debug_unit_pkg::*;
#(
    parameter int IMEM_AW    = 8,
    parameter int MAX_CYCLES = 2000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_reset,
    output logic               cpu_enable,
    input  logic               cpu_halt,
    input  logic [31:0]        cpu_pc,
    output logic [4:0]         reg_rd_addr,
    input  logic [31:0]        reg_rd_data
);

    localparam int CW = $clog2(MAX_CYCLES + 1);

    dbg_state_e         state_q, state_d;
    logic               rx_ready_q, rx_ready_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               cpu_enable_q, cpu_enable_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;
    logic [31:0]        word_q, word_d;
    logic               imem_we_q, imem_we_d;
    logic [8:0]         words_left_q, words_left_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [CW-1:0]      cyc_q, cyc_d;
    logic [7:0]         resp_q, resp_d;
    logic               resp_pend_q, resp_pend_d;
    logic               dump_after_q, dump_after_d;
    logic [31:0]        pc_q, pc_d;
    logic [5:0]         idx_q, idx_d;
    logic               rd_wait_q, rd_wait_d;
    logic [4:0]         reg_addr_q, reg_addr_d;

    logic               rx_fire;
    logic [CW-1:0]      cyc_inc;
    logic               start_resp;
    logic               start_dump;
    logic [7:0]         resp_code;
    logic               resp_then_dump;
    logic               sh_load;
    logic               sh_one;
    logic [31:0]        sh_word;
    logic               sh_done;

    assign rx_fire = rx_valid && rx_ready_q;
    assign cyc_inc = cyc_q + CW'(cpu_enable_q);

    always_comb begin
        state_d        = state_q;
        cpu_reset_d    = cpu_reset_q;
        cpu_enable_d   = cpu_enable_q;
        addr_d         = addr_q;
        word_d         = word_q;
        imem_we_d      = 1'b0;
        words_left_d   = words_left_q;
        byte_cnt_d     = byte_cnt_q;
        cyc_d          = cyc_q;
        resp_d         = resp_q;
        resp_pend_d    = 1'b0;
        dump_after_d   = dump_after_q;
        pc_d           = pc_q;
        idx_d          = idx_q;
        rd_wait_d      = rd_wait_q;
        reg_addr_d     = reg_addr_q;
        start_resp     = 1'b0;
        start_dump     = 1'b0;
        resp_code      = RSP_OK;
        resp_then_dump = 1'b0;
        sh_load        = 1'b0;
        sh_one         = 1'b0;
        sh_word        = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    case (rx_data)
                        CMD_LOAD: begin
                            state_d     = ST_LOAD_CNT;
                            cpu_reset_d = 1'b1;
                            addr_d      = '0;
                        end
                        CMD_RUN: begin
                            state_d     = ST_RUN;
                            cpu_reset_d = 1'b0;
                            cyc_d       = '0;
                        end
                        CMD_STEP: begin
                            state_d      = ST_STEP;
                            cpu_reset_d  = 1'b0;
                            cpu_enable_d = 1'b1;
                        end
                        CMD_DUMP: begin
                            start_dump = 1'b1;
                        end
                        CMD_RESET: begin
                            cpu_reset_d = 1'b1;
                            start_resp  = 1'b1;
                        end
                        default: begin
                            start_resp = 1'b1;
                            resp_code  = RSP_UNKNOWN;
                        end
                    endcase
                end
            end
            ST_LOAD_CNT: begin
                if (rx_fire) begin
                    words_left_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    byte_cnt_d   = 2'd0;
                    state_d      = ST_LOAD_BYTE;
                end
            end
            ST_LOAD_BYTE: begin
                if (rx_fire) begin
                    word_d     = {word_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d = 1'b1;
                        state_d   = ST_LOAD_WR;
                    end
                end
            end
            ST_LOAD_WR: begin
                addr_d       = addr_q + IMEM_AW'(1);
                words_left_d = words_left_q - 9'd1;
                if (words_left_q == 9'd1) begin
                    start_resp = 1'b1;
                end else begin
                    state_d = ST_LOAD_BYTE;
                end
            end
            ST_RUN: begin
                // Halt is tested first so it wins a tie with the watchdog
                if (cpu_halt) begin
                    cpu_enable_d   = 1'b0;
                    start_resp     = 1'b1;
                    resp_code      = RSP_HALT;
                    resp_then_dump = 1'b1;
                end else if (cyc_inc == CW'(MAX_CYCLES)) begin
                    cpu_enable_d   = 1'b0;
                    start_resp     = 1'b1;
                    resp_code      = RSP_TIMEOUT;
                    resp_then_dump = 1'b1;
                end else begin
                    cpu_enable_d = 1'b1;
                    cyc_d        = cyc_inc;
                end
            end
            ST_STEP: begin
                cpu_enable_d   = 1'b0;
                start_resp     = 1'b1;
                resp_then_dump = 1'b1;
            end
            ST_RESP: begin
                if (resp_pend_q) begin
                    sh_load = 1'b1;
                    sh_one  = 1'b1;
                    sh_word = {resp_q, 24'h0};
                end else if (sh_done) begin
                    if (dump_after_q) begin
                        start_dump = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DUMP_RD: begin
                // Word 0 is the captured PC; register words wait one cycle for the read port
                if (idx_q == 6'd0) begin
                    sh_load = 1'b1;
                    sh_word = pc_q;
                    state_d = ST_DUMP_TX;
                end else if (!rd_wait_q) begin
                    rd_wait_d = 1'b1;
                end else begin
                    sh_load   = 1'b1;
                    sh_word   = reg_rd_data;
                    rd_wait_d = 1'b0;
                    state_d   = ST_DUMP_TX;
                end
            end
            ST_DUMP_TX: begin
                if (sh_done) begin
                    if (idx_q == 6'(DUMP_WORDS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d      = idx_q + 6'd1;
                        reg_addr_d = idx_q[4:0];
                        state_d    = ST_DUMP_RD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_resp) begin
            state_d      = ST_RESP;
            resp_d       = resp_code;
            resp_pend_d  = 1'b1;
            dump_after_d = resp_then_dump;
        end
        if (start_dump) begin
            state_d    = ST_DUMP_RD;
            pc_d       = cpu_pc;
            idx_d      = 6'd0;
            reg_addr_d = 5'd0;
            rd_wait_d  = 1'b0;
        end

        rx_ready_d = accepts_rx(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rx_ready_q   <= 1'b0;
            cpu_reset_q  <= 1'b1;
            cpu_enable_q <= 1'b0;
            addr_q       <= '0;
            word_q       <= 32'h0;
            imem_we_q    <= 1'b0;
            words_left_q <= 9'd0;
            byte_cnt_q   <= 2'd0;
            cyc_q        <= '0;
            resp_q       <= 8'h00;
            resp_pend_q  <= 1'b0;
            dump_after_q <= 1'b0;
            pc_q         <= 32'h0;
            idx_q        <= 6'd0;
            rd_wait_q    <= 1'b0;
            reg_addr_q   <= 5'd0;
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            cpu_enable_q <= cpu_enable_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
            imem_we_q    <= imem_we_d;
            words_left_q <= words_left_d;
            byte_cnt_q   <= byte_cnt_d;
            cyc_q        <= cyc_d;
            resp_q       <= resp_d;
            resp_pend_q  <= resp_pend_d;
            dump_after_q <= dump_after_d;
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            rd_wait_q    <= rd_wait_d;
            reg_addr_q   <= reg_addr_d;
        end
    end

    mips_debug_unit_tx_shifter u_tx_shifter (
        .clk        (clk),
        .rst_ni     (reset_n),
        .load_i     (sh_load),
        .one_byte_i (sh_one),
        .word_i     (sh_word),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .done_o     (sh_done)
    );

    assign rx_ready    = rx_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = word_q;
    assign cpu_reset   = cpu_reset_q;
    assign cpu_enable  = cpu_enable_q;
    assign reg_rd_addr = reg_addr_q;

endmodule

// File: doc/mips_debug_unit.md
Name: mips_debug_unit

Overview:
- Byte-stream debug controller that sequences the MIPS pipeline from a host link, typically a UART front-end.
- Loads words into instruction memory, then holds, releases, single-steps or resets the core.
- On halt, step or watchdog expiry it streams out the PC and all 32 registers.
- Sits between the UART byte interface and the `mips` top; drives the core's reset and clock-enable.

Parameters:
- IMEM_AW, 8: instruction-memory word-address width; load address wraps modulo 2^IMEM_AW.
- MAX_CYCLES, 2000: run watchdog, in enabled cycles, before a forced stop.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rx_data  in  8  host command/data byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  unit accepts a byte; transfer when rx_valid&&rx_ready
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid; held stable until tx_ready
- tx_ready  in  1  sink accepts byte
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  IMEM_AW  word address
- imem_wdata  out  32  word to write
- cpu_reset  out  1  active-high reset to mips core
- cpu_enable  out  1  pipeline clock-enable
- cpu_halt  in  1  core halt flag
- cpu_pc  in  32  current IF PC
- reg_rd_addr  out  5  register-file debug read address
- reg_rd_data  in  32  register-file debug read data

Behaviour:
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, cpu_enable=0, reg_rd_addr=0.
- Reset is asynchronous. Asserting it mid-operation abandons any transfer, load, run or dump, and the unit returns to IDLE.
- States:
  - IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, RESP, DUMP_RD, DUMP_TX.
  - rx_ready=1 only in IDLE, LOAD_CNT and LOAD_BYTE.
- IDLE decodes the accepted byte:
  - 'L' 0x4C -> LOAD_CNT.
  - 'R' 0x52 -> RUN.
  - 'S' 0x53 -> STEP.
  - 'D' 0x44 -> DUMP.
  - 'X' 0x58 -> cpu_reset=1, then RESP 'K' 0x4B.
  - Any other byte -> RESP '?' 0x3F.
- Load:
  - LOAD_CNT takes N; N=0 means 256 words.
  - cpu_reset=1 and the word address is cleared to 0.
  - LOAD_BYTE assembles 4 bytes, MSB first.
  - LOAD_WR pulses imem_we for exactly one cycle with the current address and word, then increments the address (wraps).
  - After N words -> RESP 'K'.
- Run:
  - Entry cycle clears cpu_reset and the cycle counter; cpu_enable=1 from the next cycle.
  - If cpu_halt is sampled 1, cpu_enable drops the following cycle and the unit sends RESP 'H' 0x48, then dumps.
  - If the counter reaches MAX_CYCLES, cpu_enable drops and the unit sends RESP 'T' 0x54, then dumps.
  - If halt and timeout occur in the same cycle, halt wins.
  - R with cpu_halt already 1 gives zero enabled cycles, then 'H'.
- Step:
  - cpu_reset=0 and cpu_enable=1 for exactly one cycle.
  - Then RESP 'K', then dump.
- RESP: drives the single byte and waits for tx_ready.
- Dump:
  - 132 bytes: cpu_pc, then registers 0..31; each word MSB first.
  - DUMP_RD drives reg_rd_addr and captures data one cycle later (registered read port tolerated).
  - The PC is captured on dump entry.
  - DUMP_TX shifts 4 bytes under the tx handshake.
  - Back to IDLE after register 31's last byte.
- tx backpressure: tx_valid/tx_data never change while tx_valid&&!tx_ready.
- cpu_enable is 0 in every state except RUN/STEP enabled cycles.

Decomposition:
- Package `src/mips/mips_dbg_pkg.vh` (`define style, as mips_pkg.vh) holds:
  - command codes L/R/S/D/X;
  - response codes K/H/T/?;
  - state encodings;
  - DUMP_WORDS=33.
- Sub-module mips_dbg_tx_shifter: loads a 32-bit word and emits 4 bytes MSB first over valid/ready, with a done pulse. It is used by the dump path; RESP uses its 1-byte mode.

Test Plan:
- L,2,00000005,20010005 -> imem_we pulses at addr 0 and addr 1 with those words, one cycle each; tx 'K'; cpu_reset stays 1.
- Load the JR program, then R, with the core halting at cycle ~40 -> tx 'H' then 132 bytes; PC word first; reg1=00000005, reg2=00000064; cpu_enable=0 after halt.
- Program with an infinite loop, MAX_CYCLES=50, R -> exactly 50 cpu_enable cycles; tx 'T' then dump.
- X, then S -> cpu_enable high exactly 1 cycle; tx 'K'; dumped PC = 00000004.
- Byte 0x7A -> tx '?' only; no imem_we; cpu_enable stays 0.
- D with tx_ready stalled 5 cycles per byte -> tx_data stable throughout stalls.
- reset_n low at dump byte 60 -> all outputs return to reset values immediately.
- After the reset above, a new D -> full 132-byte dump.
